// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Define REG_FILE_ZERO_REG_EN to hardwire register 0 to zero.
`timescale 1ns/1ps
package reg_file_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_NREAD = 2;

`ifdef REG_FILE_ZERO_REG_EN
  localparam bit ZERO_REG_EN = 1'b1;
`else
  localparam bit ZERO_REG_EN = 1'b0;
`endif

  // A DEPTH of 2 still needs one address bit.
  function automatic int addr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Write and read bus of the register file: two write ports and NREAD
// combinational read ports packed into flat vectors.
`timescale 1ns/1ps
interface reg_file_mp_if
  import reg_file_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int NREAD = DEF_NREAD
) ();

  localparam int AW = addr_width(DEPTH);

  logic                   wr0;
  logic [AW-1:0]          wr_addr0;
  logic [WIDTH-1:0]       d_in0;
  logic                   wr1;
  logic [AW-1:0]          wr_addr1;
  logic [WIDTH-1:0]       d_in1;
  logic [NREAD*AW-1:0]    rd_addr;
  logic [NREAD*WIDTH-1:0] d_out;
  logic [NREAD-1:0]       d_valid;

  modport master (
    output wr0, wr_addr0, d_in0,
    output wr1, wr_addr1, d_in1,
    output rd_addr,
    input  d_out, d_valid
  );

  modport slave (
    input  wr0, wr_addr0, d_in0,
    input  wr1, wr_addr1, d_in1,
    input  rd_addr,
    output d_out, d_valid
  );

endinterface

// File: rtl/rf_read_port.sv
// One combinational read port: register select, write-through bypass
// (port 1 wins over port 0) and the optional zero register (REG_FILE_ZERO_REG_EN).
`timescale 1ns/1ps
module rf_read_port
  import reg_file_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = addr_width(DEPTH)
) (
  input  logic                        reset,
  input  logic [AW-1:0]               rd_addr,
  input  logic [DEPTH-1:0][WIDTH-1:0] regs,
  input  logic [DEPTH-1:0]            valid,
  input  logic                        wr0,
  input  logic [AW-1:0]               wr_addr0,
  input  logic [WIDTH-1:0]            d_in0,
  input  logic                        wr1,
  input  logic [AW-1:0]               wr_addr1,
  input  logic [WIDTH-1:0]            d_in1,
  output logic [WIDTH-1:0]            d_out,
  output logic                        d_valid
);

  // Reset forces the port to zero so bypass cannot leak data during reset.
  always_comb begin
    d_out   = '0;
    d_valid = 1'b0;
    if (!reset) begin
      if (ZERO_REG_EN && rd_addr == '0) begin
        d_out   = '0;
        d_valid = 1'b1;
      end else if (wr1 && wr_addr1 == rd_addr) begin
        d_out   = d_in1;
        d_valid = 1'b1;
      end else if (wr0 && wr_addr0 == rd_addr) begin
        d_out   = d_in0;
        d_valid = 1'b1;
      end else begin
        d_out   = regs[rd_addr];
        d_valid = valid[rd_addr];
      end
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Register file with two write ports and NREAD bypassed read ports.
// Define REG_FILE_ZERO_REG_EN to make register 0 a constant zero.
`timescale 1ns/1ps
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int NREAD = DEF_NREAD
) (
  input logic           clk,
  input logic           reset,
  reg_file_mp_if.slave  bus
);

  localparam int AW = addr_width(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic [DEPTH-1:0]            valid;
  logic [WIDTH-1:0]            rd_data [NREAD];
  logic                        rd_vld  [NREAD];

  function automatic logic writable(input logic [AW-1:0] addr);
    return !(ZERO_REG_EN && addr == '0);
  endfunction

  // Port 1 is applied last so it wins a same-address collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs  <= '0;
      valid <= '0;
    end else begin
      if (bus.wr0 && writable(bus.wr_addr0)) begin
        regs[bus.wr_addr0]  <= bus.d_in0;
        valid[bus.wr_addr0] <= 1'b1;
      end
      if (bus.wr1 && writable(bus.wr_addr1)) begin
        regs[bus.wr_addr1]  <= bus.d_in1;
        valid[bus.wr_addr1] <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    rf_read_port #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_rd (
      .reset    (reset),
      .rd_addr  (bus.rd_addr[k*AW +: AW]),
      .regs     (regs),
      .valid    (valid),
      .wr0      (bus.wr0),
      .wr_addr0 (bus.wr_addr0),
      .d_in0    (bus.d_in0),
      .wr1      (bus.wr1),
      .wr_addr1 (bus.wr_addr1),
      .d_in1    (bus.d_in1),
      .d_out    (rd_data[k]),
      .d_valid  (rd_vld[k])
    );
  end

  always_comb begin
    bus.d_out   = '0;
    bus.d_valid = '0;
    for (int k = 0; k < NREAD; k++) begin
      bus.d_out[k*WIDTH +: WIDTH] = rd_data[k];
      bus.d_valid[k]              = rd_vld[k];
    end
  end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter: WIDTH, 16, data word width in bits (1..64).
REQ-002 Parameter: DEPTH, 8, number of registers (power of two, 2..256); AW = clog2(DEPTH).
REQ-003 Parameter: NREAD, 2, number of read ports (1..4).
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: wr0  input  1  write enable, write port 0.
REQ-007 Port: wr_addr0  input  AW  write address, port 0.
REQ-008 Port: d_in0  input  WIDTH  write data, port 0.
REQ-009 Port: wr1  input  1  write enable, write port 1.
REQ-010 Port: wr_addr1  input  AW  write address, port 1.
REQ-011 Port: d_in1  input  WIDTH  write data, port 1.
REQ-012 Port: rd_addr  input  NREAD*AW  read addresses; port k at bits [k*AW +: AW].
REQ-013 Port: d_out  output  NREAD*WIDTH  read data; port k at bits [k*WIDTH +: WIDTH].
REQ-014 Port: d_valid  output  NREAD  bit k = selected register written since reset.

Function
REQ-015 Storage: DEPTH x WIDTH registers plus one valid bit per register.
REQ-016 Write: on rising clk with wrN=1, reg[wr_addrN] <= d_inN, valid[wr_addrN] <= 1.
REQ-017 Dual-write collision: wr0=wr1=1, same address -> port 1 data stored, port 0 dropped.
REQ-018 Distinct write addresses: both writes commit in the same cycle.
REQ-019 Read: combinational, zero latency; d_out[k] = reg[rd_addr[k]], d_valid[k] = valid[rd_addr[k]].
REQ-020 Bypass: rd_addr[k] matching an active write address -> d_out[k] = that write's d_in, d_valid[k]=1, same cycle.
REQ-021 Bypass with both writes matching -> port 1 data forwarded, consistent with REQ-017.
REQ-022 Any number of read ports may select the same address simultaneously.
REQ-023 X/unknown address with wr=0 has no effect on stored state.

Reset
REQ-024 reset=1 immediately clears all registers to 0 and all valid bits to 0, independent of clk.
REQ-025 While reset=1: writes ignored, d_out all 0, d_valid all 0, bypass disabled.
REQ-026 Reset asserted mid-cycle with a write pending -> write is lost; first write is accepted on the first rising clk after reset deasserts.

Configuration
REQ-027 Macro REG_FILE_ZERO_REG_EN defined: register 0 hardwired; reads of address 0 return 0 with d_valid=1, writes to address 0 discarded, no bypass on address 0.
REQ-028 Macro undefined: address 0 is an ordinary register per REQ-016..REQ-021.

Structure
REQ-029 Package reg_file_pkg holds default WIDTH/DEPTH/NREAD constants and the AW computation function.
REQ-030 One sub-module, rf_read_port, instantiated NREAD times: address decode, bypass compare, output mux.

Verification
REQ-031 Reset 12.5 ns then write 0xCDEF->r3, 0x3210->r7 -> read a=3, b=7 gives 0xCDEF/0x3210, d_valid=2'b11.
REQ-032 Unwritten r5 read after reset -> d_out=0, d_valid=0; write 0x4567 to r5 with rd_addr=5 same cycle -> 0x4567, d_valid=1 before the edge (bypass).
REQ-033 wr0=wr1=1, both address 2, d_in0=0x1111, d_in1=0x2222 -> bypass and post-edge read both 0x2222.
REQ-034 wr0 -> r1=0xBA98 and wr1 -> r6=0x0F0F same edge -> both readable next cycle.
REQ-035 Assert reset between edges after filling all registers -> all d_out=0, d_valid=0 at once, no clk needed.
REQ-036 REG_FILE_ZERO_REG_EN defined: write 0xFFFF to r0 -> read r0 = 0x0000, d_valid=1; undefined: read r0 = 0xFFFF.
